dallanma_guncelleme_birimi: RTL and testbench

Resolution-side partner of the bimodal branch predictor. It queues every prediction issued at fetch, matches each one in order against the branch outcome computed in execute, and drives the predictor update bus (guncelle_*). On a misprediction it raises dallanma_hata with the corrected program counter for the PC generator.

---
 rtl/dallanma_guncelleme_birimi_pkg.sv | 23 ++
 rtl/dallanma_guncelleme_birimi_if.sv | 41 ++++
 rtl/dallanma_guncelleme_birimi_fifo.sv | 56 +++++
 rtl/dallanma_guncelleme_birimi.sv | 144 ++++++++++++++
 tb/tb_dallanma_guncelleme_birimi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dallanma_guncelleme_birimi_pkg.sv
// dallanma_guncelleme_birimi_pkg
// Shared definitions for the branch resolution / predictor update unit:
// FSM state encoding, FIFO entry field widths and the sequential PC step.
package dallanma_guncelleme_birimi_pkg;

  // CALIS: normal operation, TEMIZLE: one-cycle flush window after a redirect
  typedef enum logic {
    CALIS   = 1'b0,
    TEMIZLE = 1'b1
  } durum_t;

  // Width of the predicted-taken field inside a queue entry
  localparam int ATLADI_GENISLIK = 1;

  // Byte distance to the next sequential instruction
  localparam int PS_ARTIS = 4;

  // Entry layout is {ps, atladi, hedef}
  function automatic int giris_genisligi(input int ps_genislik);
    return (2 * ps_genislik) + ATLADI_GENISLIK;
  endfunction

endpackage

// File: rtl/dallanma_guncelleme_birimi_if.sv
// dallanma_guncelleme_birimi_if
// Groups the fetch-side prediction push, the execute-side resolution pop,
// the predictor update bus, the redirect and the statistics counters.
// master = fetch/execute/predictor side, slave = the update unit.
interface dallanma_guncelleme_birimi_if #(
  parameter int PS_GENISLIK = 32
);
  logic                   ongoru_gecerli_i;
  logic [PS_GENISLIK-1:0] ongoru_ps_i;
  logic                   ongoru_atladi_i;
  logic [PS_GENISLIK-1:0] ongoru_hedef_i;
  logic                   kuyruk_dolu_o;
  logic                   kuyruk_bos_o;
  logic                   cozum_gecerli_i;
  logic                   cozum_atladi_i;
  logic [PS_GENISLIK-1:0] cozum_hedef_i;
  logic                   guncelle_gecerli_o;
  logic                   guncelle_atladi_o;
  logic [PS_GENISLIK-1:0] guncelle_ps_o;
  logic [PS_GENISLIK-1:0] guncelle_hedef_adresi_o;
  logic                   dallanma_hata_o;
  logic [PS_GENISLIK-1:0] duzeltilmis_ps_o;
  logic [31:0]            dogru_sayisi_o;
  logic [31:0]            hata_sayisi_o;

  modport master (
    output ongoru_gecerli_i, ongoru_ps_i, ongoru_atladi_i, ongoru_hedef_i,
    output cozum_gecerli_i, cozum_atladi_i, cozum_hedef_i,
    input  kuyruk_dolu_o, kuyruk_bos_o,
    input  guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_adresi_o,
    input  dallanma_hata_o, duzeltilmis_ps_o, dogru_sayisi_o, hata_sayisi_o
  );

  modport slave (
    input  ongoru_gecerli_i, ongoru_ps_i, ongoru_atladi_i, ongoru_hedef_i,
    input  cozum_gecerli_i, cozum_atladi_i, cozum_hedef_i,
    output kuyruk_dolu_o, kuyruk_bos_o,
    output guncelle_gecerli_o, guncelle_atladi_o, guncelle_ps_o, guncelle_hedef_adresi_o,
    output dallanma_hata_o, duzeltilmis_ps_o, dogru_sayisi_o, hata_sayisi_o
  );
endinterface

// File: rtl/dallanma_guncelleme_birimi_fifo.sv
// dallanma_fifo
// Circular buffer of in-flight predictions with synchronous push, pop and
// whole-queue flush. DERINLIK is a power of two so pointers wrap naturally.
// The caller only pushes when there is room (or a pop frees a slot in the
// same cycle) and only pops when not empty. Flush wins over push and pop.
module dallanma_fifo #(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = 65
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [GENISLIK-1:0] veri_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic [GENISLIK-1:0] bas_o,
  output logic                dolu_o,
  output logic                bos_o
);
  localparam int PW = $clog2(DERINLIK);

  logic [GENISLIK-1:0] r_bellek [DERINLIK];
  logic [PW-1:0]       r_yaz;
  logic [PW-1:0]       r_oku;
  logic [PW:0]         r_sayac;

  // Pointer and occupancy bookkeeping; a flush drops every entry at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_yaz   <= '0;
      r_oku   <= '0;
      r_sayac <= '0;
    end else if (flush_i) begin
      r_yaz   <= '0;
      r_oku   <= '0;
      r_sayac <= '0;
    end else begin
      if (push_i) r_yaz <= r_yaz + 1'b1;
      if (pop_i)  r_oku <= r_oku + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_sayac <= r_sayac + 1'b1;
        2'b01:   r_sayac <= r_sayac - 1'b1;
        default: r_sayac <= r_sayac;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone defines what is valid
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_bellek[r_yaz] <= veri_i;
  end

  assign bas_o  = r_bellek[r_oku];
  assign dolu_o = (r_sayac == (PW+1)'(DERINLIK));
  assign bos_o  = (r_sayac == '0);
endmodule

// File: rtl/dallanma_guncelleme_birimi.sv
// dallanma_guncelleme_birimi
// Queues fetch-time predictions, checks each against the execute-stage
// outcome in order, drives the predictor update bus and raises a redirect on
// a misprediction. Optional statistics counters: DALLANMA_SAYAC_EN.
module dallanma_guncelleme_birimi
  import dallanma_guncelleme_birimi_pkg::*;
#(
  parameter int DERINLIK    = 4,
  parameter int PS_GENISLIK = 32
) (
  input logic                         clk_i,
  input logic                         rst_i,
  dallanma_guncelleme_birimi_if.slave bus
);
  localparam int GIRIS_G = giris_genisligi(PS_GENISLIK);

  durum_t                 r_durum;
  durum_t                 w_sonraki;
  logic [GIRIS_G-1:0]     w_giris;
  logic [GIRIS_G-1:0]     w_bas;
  logic [PS_GENISLIK-1:0] w_bas_ps;
  logic                   w_bas_atladi;
  logic [PS_GENISLIK-1:0] w_bas_hedef;
  logic                   w_dolu;
  logic                   w_bos;
  logic                   w_calis;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_hata;
  logic                   w_flush;
  logic [PS_GENISLIK-1:0] w_duzeltilmis;

  logic                   r_guncelle_gecerli;
  logic                   r_guncelle_atladi;
  logic [PS_GENISLIK-1:0] r_guncelle_ps;
  logic [PS_GENISLIK-1:0] r_guncelle_hedef;
  logic                   r_dallanma_hata;
  logic [PS_GENISLIK-1:0] r_duzeltilmis_ps;

  assign w_giris      = {bus.ongoru_ps_i, bus.ongoru_atladi_i, bus.ongoru_hedef_i};
  assign w_bas_ps     = w_bas[GIRIS_G-1 -: PS_GENISLIK];
  assign w_bas_atladi = w_bas[PS_GENISLIK];
  assign w_bas_hedef  = w_bas[PS_GENISLIK-1:0];

  assign w_calis = (r_durum == CALIS);
  assign w_pop   = bus.cozum_gecerli_i && !w_bos && w_calis;

  // Wrong direction, or right "taken" direction with the wrong target
  assign w_hata = (w_bas_atladi != bus.cozum_atladi_i) ||
                  (w_bas_atladi && bus.cozum_atladi_i && (w_bas_hedef != bus.cozum_hedef_i));

  assign w_flush = w_pop && w_hata;

  // A same-cycle pop frees the slot, so a push into a full queue is fine then;
  // a push alongside a mispredicting pop is wrong-path and is dropped
  assign w_push = bus.ongoru_gecerli_i && (!w_dolu || w_pop) && w_calis && !w_flush;

  assign w_duzeltilmis = bus.cozum_atladi_i ? bus.cozum_hedef_i
                                            : (w_bas_ps + PS_GENISLIK'(PS_ARTIS));

  dallanma_fifo #(
    .DERINLIK (DERINLIK),
    .GENISLIK (GIRIS_G)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .veri_i  (w_giris),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .bas_o   (w_bas),
    .dolu_o  (w_dolu),
    .bos_o   (w_bos)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_durum <= CALIS;
    else        r_durum <= w_sonraki;
  end

  // Next state: a misprediction opens a single-cycle flush window
  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      CALIS:   if (w_flush) w_sonraki = TEMIZLE;
      TEMIZLE: w_sonraki = CALIS;
      default: w_sonraki = CALIS;
    endcase
  end

  // Registered update bus and redirect, one cycle after the accepted pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_guncelle_gecerli <= 1'b0;
      r_guncelle_atladi  <= 1'b0;
      r_guncelle_ps      <= '0;
      r_guncelle_hedef   <= '0;
      r_dallanma_hata    <= 1'b0;
      r_duzeltilmis_ps   <= '0;
    end else begin
      r_guncelle_gecerli <= w_pop;
      r_guncelle_atladi  <= w_pop && bus.cozum_atladi_i;
      r_guncelle_ps      <= w_pop ? w_bas_ps : '0;
      r_guncelle_hedef   <= (w_pop && bus.cozum_atladi_i) ? bus.cozum_hedef_i : '0;
      r_dallanma_hata    <= w_flush;
      r_duzeltilmis_ps   <= w_flush ? w_duzeltilmis : '0;
    end
  end

  assign bus.kuyruk_dolu_o           = w_dolu;
  assign bus.kuyruk_bos_o            = w_bos;
  assign bus.guncelle_gecerli_o      = r_guncelle_gecerli;
  assign bus.guncelle_atladi_o       = r_guncelle_atladi;
  assign bus.guncelle_ps_o           = r_guncelle_ps;
  assign bus.guncelle_hedef_adresi_o = r_guncelle_hedef;
  assign bus.dallanma_hata_o         = r_dallanma_hata;
  assign bus.duzeltilmis_ps_o        = r_duzeltilmis_ps;

`ifdef DALLANMA_SAYAC_EN
  logic [31:0] r_dogru_sayisi;
  logic [31:0] r_hata_sayisi;

  // Saturating statistics, counted on the cycle the update is presented
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dogru_sayisi <= '0;
      r_hata_sayisi  <= '0;
    end else if (r_guncelle_gecerli) begin
      if (r_dallanma_hata) begin
        if (r_hata_sayisi != '1) r_hata_sayisi <= r_hata_sayisi + 1'b1;
      end else begin
        if (r_dogru_sayisi != '1) r_dogru_sayisi <= r_dogru_sayisi + 1'b1;
      end
    end
  end

  assign bus.dogru_sayisi_o = r_dogru_sayisi;
  assign bus.hata_sayisi_o  = r_hata_sayisi;
`else
  assign bus.dogru_sayisi_o = '0;
  assign bus.hata_sayisi_o  = '0;
`endif
endmodule

// File: tb/tb_dallanma_guncelleme_birimi.sv
// tb_dallanma_guncelleme_birimi
// Scoreboard bench: a queue-based reference model of the prediction FIFO
// produces the expected update for every resolution; a monitor compares them
// against the DUT update bus one cycle later. Honours DALLANMA_SAYAC_EN.
module tb_dallanma_guncelleme_birimi;
  localparam int D = 4;

  typedef struct {
    logic [31:0] ps;
    logic        atladi;
    logic [31:0] hedef;
  } tahmin_t;

  typedef struct {
    int          due;
    logic [31:0] ps;
    logic        atladi;
    logic [31:0] hedef;
    logic        hata;
    logic [31:0] duz;
  } beklenen_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dogruSay = 0;
  int   hataSay = 0;
  bit   modelTemizle = 1'b0;

  tahmin_t   modelQ[$];
  beklenen_t expQ[$];

  dallanma_guncelleme_birimi_if #(.PS_GENISLIK(32)) bus ();

  dallanma_guncelleme_birimi #(
    .DERINLIK    (D),
    .PS_GENISLIK (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .bus   (bus.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle stamp used to time expected update pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare queue flags and counters against the model
  task automatic checkOutput(input bit withCounters);
    check32("kuyruk_bos", 32'(bus.kuyruk_bos_o), 32'(modelQ.size() == 0));
    check32("kuyruk_dolu", 32'(bus.kuyruk_dolu_o), 32'(modelQ.size() == D));
    if (withCounters) begin
`ifdef DALLANMA_SAYAC_EN
      check32("dogru_sayisi", bus.dogru_sayisi_o, 32'(dogruSay));
      check32("hata_sayisi", bus.hata_sayisi_o, 32'(hataSay));
`else
      check32("dogru_sayisi", bus.dogru_sayisi_o, 32'd0);
      check32("hata_sayisi", bus.hata_sayisi_o, 32'd0);
`endif
    end
  endtask

  // One cycle: called at a negedge, drives inputs, advances the model, returns at the next negedge
  task automatic applyStimulus(input bit push, input logic [31:0] ps, input bit at,
                               input logic [31:0] hd, input bit pop, input bit cat,
                               input logic [31:0] chd);
    bit        popOk;
    bit        pushOk;
    bit        hata;
    tahmin_t   head;
    tahmin_t   yeni;
    beklenen_t e;
    checkOutput(1'b0);
    bus.ongoru_gecerli_i = push;
    bus.ongoru_ps_i      = ps;
    bus.ongoru_atladi_i  = at;
    bus.ongoru_hedef_i   = hd;
    bus.cozum_gecerli_i  = pop;
    bus.cozum_atladi_i   = cat;
    bus.cozum_hedef_i    = chd;
    if (modelTemizle) begin
      modelTemizle = 1'b0;
    end else begin
      popOk  = pop && (modelQ.size() > 0);
      pushOk = push && ((modelQ.size() < D) || popOk);
      if (popOk) begin
        head     = modelQ.pop_front();
        hata     = (head.atladi != cat) || (head.atladi && cat && (head.hedef != chd));
        e.due    = cyc + 1;
        e.ps     = head.ps;
        e.atladi = cat;
        e.hedef  = cat ? chd : 32'd0;
        e.hata   = hata;
        e.duz    = cat ? chd : head.ps + 32'd4;
        expQ.push_back(e);
        if (hata) begin
          modelQ.delete();
          modelTemizle = 1'b1;
          pushOk = 1'b0;
          hataSay++;
        end else begin
          dogruSay++;
        end
      end
      if (pushOk) begin
        yeni.ps = ps;
        yeni.atladi = at;
        yeni.hedef = hd;
        modelQ.push_back(yeni);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every negedge either the due update appears or the bus stays quiet
  initial begin
    beklenen_t e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (expQ.size() > 0 && expQ[0].due < cyc) begin
          e = expQ.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missed_update: got none expected ps %h at cycle %0d", e.ps, e.due);
        end
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
          e = expQ.pop_front();
          check32("guncelle_gecerli", 32'(bus.guncelle_gecerli_o), 32'd1);
          check32("guncelle_ps", bus.guncelle_ps_o, e.ps);
          check32("guncelle_atladi", 32'(bus.guncelle_atladi_o), 32'(e.atladi));
          check32("guncelle_hedef", bus.guncelle_hedef_adresi_o, e.hedef);
          check32("dallanma_hata", 32'(bus.dallanma_hata_o), 32'(e.hata));
          if (e.hata) check32("duzeltilmis_ps", bus.duzeltilmis_ps_o, e.duz);
        end else begin
          check32("guncelle_idle", 32'(bus.guncelle_gecerli_o), 32'd0);
          check32("hata_idle", 32'(bus.dallanma_hata_o), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] rps, rhd, chd;
    bit          rat, cat;
    bus.ongoru_gecerli_i = 0;
    bus.ongoru_ps_i      = 0;
    bus.ongoru_atladi_i  = 0;
    bus.ongoru_hedef_i   = 0;
    bus.cozum_gecerli_i  = 0;
    bus.cozum_atladi_i   = 0;
    bus.cozum_hedef_i    = 0;
    repeat (2) @(negedge clk);
    check32("rst_guncelle", 32'(bus.guncelle_gecerli_o), 32'd0);
    check32("rst_hata", 32'(bus.dallanma_hata_o), 32'd0);
    check32("rst_duz", bus.duzeltilmis_ps_o, 32'd0);
    checkOutput(1'b1);
    rstN = 1'b1;

    // Correct taken prediction
    applyStimulus(1, 32'h100, 1, 32'h200, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h200);
    idle(2);
    // Direction mispredict, same-cycle push dropped, push during flush ignored
    applyStimulus(1, 32'h300, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 32'h999, 1, 32'h111, 1, 1, 32'h340);
    applyStimulus(1, 32'hAAA, 0, 32'h0, 0, 0, 0);
    idle(2);
    // Target mispredict
    applyStimulus(1, 32'h400, 1, 32'h500, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h520);
    idle(2);
    // Redirect to ps+4 wraps past the top of the address space
    applyStimulus(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    idle(2);
    // Fill, overflow push, push+pop while full, drain in order
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h1000 + 32'(i * 4), 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h2000, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    // Resolution with nothing queued
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h44);
    idle(2);
    checkOutput(1'b1);

    // Randomized traffic, outcomes usually agreeing with the queued prediction
    for (int n = 0; n < 400; n++) begin
      rps = 32'($urandom_range(0, 255)) << 2;
      rat = 1'($urandom_range(0, 1));
      rhd = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
      if (modelQ.size() > 0 && $urandom_range(0, 3) != 0) begin
        cat = modelQ[0].atladi;
        chd = modelQ[0].hedef;
      end else begin
        cat = 1'($urandom_range(0, 1));
        chd = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
      end
      applyStimulus(1'($urandom_range(0, 1)), rps, rat, rhd, 1'($urandom_range(0, 1)), cat, chd);
    end
    idle(3);
    checkOutput(1'b1);

    // Asynchronous reset while an update is on the bus and three entries wait
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h3000 + 32'(i * 4), 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    #2;
    rstN = 1'b0;
    #1;
    modelQ.delete();
    expQ.delete();
    modelTemizle = 1'b0;
    dogruSay = 0;
    hataSay = 0;
    check32("async_guncelle", 32'(bus.guncelle_gecerli_o), 32'd0);
    check32("async_ps", bus.guncelle_ps_o, 32'd0);
    check32("async_hata", 32'(bus.dallanma_hata_o), 32'd0);
    checkOutput(1'b1);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 32'h500, 1, 32'h600, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h600);
    idle(3);
    checkOutput(1'b1);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_updates: got %0d left expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
